// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states, status flags.
// Used by seq_alu and alu_iter_unit.
package alu_pkg;

    localparam logic [5:0] OP_AND  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_ANDI = 6'd3;
    localparam logic [5:0] OP_ADDI = 6'd4;
    localparam logic [5:0] OP_OR   = 6'd5;
    localparam logic [5:0] OP_XOR  = 6'd6;
    localparam logic [5:0] OP_SLL  = 6'd7;
    localparam logic [5:0] OP_SRL  = 6'd8;
    localparam logic [5:0] OP_SRA  = 6'd9;
    localparam logic [5:0] OP_MUL  = 6'd10;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
        logic illegal;
    } flags_t;

    function automatic logic is_shift(input logic [5:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: one-bit-per-cycle shifts and (with SEQ_ALU_MUL_EN)
// an unsigned shift-add multiplier. result/carry show the value after this step.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    logic             busy;
    logic [5:0]       op_r;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_next;
    logic             carry_next;

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   mplier;

    // add the shifted multiplicand when the current multiplier bit is set
    always_comb prod_next = prod + (mplier[0] ? mcand : '0);
`else
    logic unused_b;
    assign unused_b = ^b[WIDTH-1:SW];
`endif

    // one step of the operation in flight
    always_comb begin
        acc_next   = acc;
        carry_next = 1'b0;
        case (op_r)
            OP_SLL: begin
                acc_next   = {acc[WIDTH-2:0], 1'b0};
                carry_next = acc[WIDTH-1];
            end
            OP_SRL: begin
                acc_next   = {1'b0, acc[WIDTH-1:1]};
                carry_next = acc[0];
            end
            OP_SRA: begin
                acc_next   = {acc[WIDTH-1], acc[WIDTH-1:1]};
                carry_next = acc[0];
            end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin
                acc_next   = prod_next[WIDTH-1:0];
                carry_next = |prod_next[2*WIDTH-1:WIDTH];
            end
`endif
            default: ;
        endcase
    end

    assign done   = busy && (cnt == CW'(1));
    assign result = acc_next;
    assign carry  = carry_next;

    // load operands on start, then step until the count runs out
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            op_r <= '0;
            acc  <= '0;
            cnt  <= '0;
`ifdef SEQ_ALU_MUL_EN
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
`endif
        end else if (start) begin
            busy <= 1'b1;
            op_r <= op;
            acc  <= a;
            cnt  <= {1'b0, b[SW-1:0]};
`ifdef SEQ_ALU_MUL_EN
            if (op == OP_MUL) cnt <= CW'(WIDTH);
            prod   <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
`endif
        end else if (busy) begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) busy <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            prod   <= prod_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
`endif
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes and registered result/flags.
// Define SEQ_ALU_MUL_EN to build in the iterative multiplier (opcode 10).
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             illegal
);

    localparam int SW = $clog2(WIDTH);

    state_t           state;
    flags_t           flags;
    logic [WIDTH-1:0] res_r;
    logic             use_iter;
    logic             it_start;
    logic             it_done;
    logic             it_carry;
    logic             it_ovf;
    logic [WIDTH-1:0] it_result;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_ovf;
    logic             sc_ill;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_r;
    assign carry     = flags.carry;
    assign zero      = flags.zero;
    assign negative  = flags.negative;
    assign overflow  = flags.overflow;
    assign illegal   = flags.illegal;

`ifdef SEQ_ALU_MUL_EN
    logic mul_r;
    assign it_ovf = mul_r & it_carry;
    always_comb use_iter = (is_shift(opcode) && (b[SW-1:0] != '0))
                        || (opcode == OP_MUL);
`else
    assign it_ovf = 1'b0;
    always_comb use_iter = is_shift(opcode) && (b[SW-1:0] != '0);
`endif

    assign it_start = (state == IDLE) && in_valid && use_iter && !reset;

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (it_start),
        .op     (opcode),
        .a      (a),
        .b      (b),
        .done   (it_done),
        .result (it_result),
        .carry  (it_carry)
    );

    // single-cycle ops, zero-distance shifts and illegal opcodes
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_ill   = 1'b0;
        case (opcode)
            OP_AND, OP_ANDI: sc_res = a & b;
            OP_ADD, OP_ADDI: begin
                {sc_carry, sc_res} = {1'b0, a} + {1'b0, b};
                sc_ovf = (a[WIDTH-1] == b[WIDTH-1])
                      && (sc_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = a - b;
                sc_carry = (b > a);
                sc_ovf   = (a[WIDTH-1] != b[WIDTH-1])
                        && (sc_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_SLL, OP_SRL, OP_SRA: sc_res = a;
            default: sc_ill = 1'b1;
        endcase
    end

    // control FSM; result and flags only load on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            res_r <= '0;
            flags <= '0;
`ifdef SEQ_ALU_MUL_EN
            mul_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    if (use_iter) begin
                        state <= EXEC;
`ifdef SEQ_ALU_MUL_EN
                        mul_r <= (opcode == OP_MUL);
`endif
                    end else begin
                        state          <= DONE;
                        res_r          <= sc_res;
                        flags.carry    <= sc_carry;
                        flags.zero     <= (sc_res == '0);
                        flags.negative <= sc_res[WIDTH-1];
                        flags.overflow <= sc_ovf;
                        flags.illegal  <= sc_ill;
                    end
                end
                EXEC: if (it_done) begin
                    state          <= DONE;
                    res_r          <= it_result;
                    flags.carry    <= it_carry;
                    flags.zero     <= (it_result == '0);
                    flags.negative <= it_result[WIDTH-1];
                    flags.overflow <= it_ovf;
                    flags.illegal  <= 1'b0;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         negative;
    logic         overflow;
    logic         illegal;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   fl;
        int           lat;
    } exp_t;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] dut_fl();
        return {carry, zero, negative, overflow, illegal};
    endfunction

    // reference: plain arithmetic on wide / signed values
    function automatic exp_t model(input logic [5:0] op,
                                   input logic [W-1:0] av,
                                   input logic [W-1:0] bv);
        exp_t   e;
        logic [63:0] w;
        logic signed [63:0] sw;
        longint s;
        int     sh;
        logic   c, v, il;
        sh  = int'(bv[4:0]);
        c   = 1'b0;
        v   = 1'b0;
        il  = 1'b0;
        e.lat = 1;
        e.res = '0;
        case (op)
            6'd0, 6'd3: e.res = av & bv;
            6'd1, 6'd4: begin
                w = {32'b0, av} + {32'b0, bv};
                e.res = w[31:0];
                c = w[32];
                s = longint'($signed(av)) + longint'($signed(bv));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            6'd2: begin
                e.res = av - bv;
                c = (bv > av);
                s = longint'($signed(av)) - longint'($signed(bv));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            6'd5: e.res = av | bv;
            6'd6: e.res = av ^ bv;
            6'd7: begin
                w = {32'b0, av} << sh;
                e.res = w[31:0];
                c = w[32];
                e.lat = sh + 1;
            end
            6'd8: begin
                w = {av, 32'b0} >> sh;
                e.res = w[63:32];
                c = w[31];
                e.lat = sh + 1;
            end
            6'd9: begin
                sw = $signed({av, 32'b0}) >>> sh;
                e.res = sw[63:32];
                c = sw[31];
                e.lat = sh + 1;
            end
`ifdef SEQ_ALU_MUL_EN
            6'd10: begin
                w = {32'b0, av} * {32'b0, bv};
                e.res = w[31:0];
                c = (w[63:32] != 0);
                v = c;
                e.lat = W + 1;
            end
`endif
            default: begin
                e.res = '0;
                il = 1'b1;
            end
        endcase
        e.fl = {c, (e.res == 0), e.res[W-1], v, il};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // issue one op, check latency/result/flags, hold backpressure, release
    task automatic run_op(input string tag, input logic [5:0] op,
                          input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int hold);
        exp_t e;
        int   lat;
        e = model(op, av, bv);
        @(negedge clk);
        chk({tag, "/rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        opcode   = op;
        a        = av;
        b        = bv;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "/lat"}, 64'(lat), 64'(e.lat));
        chk({tag, "/res"}, 64'(result), 64'(e.res));
        chk({tag, "/fl"}, 64'(dut_fl()), 64'(e.fl));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "/hv"}, 64'({out_valid, in_ready}), 64'b10);
            chk({tag, "/hr"}, 64'({result, dut_fl()}), 64'({e.res, e.fl}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/idle"}, 64'({out_valid, in_ready}), 64'b01);
    endtask

    initial begin
        logic [5:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [5:0]   lop;
        logic [W-1:0] lb;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        a         = '0;
        b         = '0;
        repeat (2) @(negedge clk);
        chk("rst/hs", 64'({out_valid, in_ready}), 64'b01);
        chk("rst/res", 64'(result), 64'd0);
        chk("rst/fl", 64'(dut_fl()), 64'd0);
        reset = 1'b0;

        run_op("add_wrap", 6'd1, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sub_ovf", 6'd2, 32'h8000_0000, 32'h1, 0);
        run_op("sra4", 6'd9, 32'h8000_0000, 32'd4, 0);
        run_op("sra0", 6'd9, 32'h8000_0000, 32'd0, 0);
        run_op("sll31", 6'd7, 32'h0000_0003, 32'd31, 1);
        run_op("srl1", 6'd8, 32'h0000_0003, 32'd1, 0);
        run_op("mul", 6'd10, 32'h0001_0000, 32'h0001_0000, 0);
        run_op("illegal", 6'd63, 32'h1234_5678, 32'h9, 0);
        run_op("bp_add", 6'd1, 32'd3, 32'd4, 5);
        chk("bp/seven", 64'(result), 64'd7);

`ifdef SEQ_ALU_MUL_EN
        lop = 6'd10;
        lb  = 32'h0000_0005;
`else
        lop = 6'd7;
        lb  = 32'd31;
`endif
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = lop;
        a        = 32'h0000_0007;
        b        = lb;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid/busy", 64'({out_valid, in_ready}), 64'b00);
        reset    = 1'b1;
        in_valid = 1'b1;
        opcode   = 6'd1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mid/hs", 64'({out_valid, in_ready}), 64'b01);
        chk("mid/fl", 64'({result, dut_fl()}), 64'd0);
        run_op("and_after", 6'd0, 32'hF0, 32'h3C, 0);
        chk("and/30", 64'(result), 64'h30);

        for (int i = 0; i < 60; i++) begin
            rop = 6'($urandom_range(0, 12));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 7 == 0) ra = 32'h8000_0000 | ra;
            run_op("rand", rop, ra, rb, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
